div_ctrl: RTL and testbench

- Iterative restoring divider and sequencer for MIPS DIV/DIVU in the execute stage; one quotient bit per cycle.
- Drives div_running into the hazard unit, which holds F/D/E stalled while a divide is in flight.
- Delivers quotient/remainder for the HI/LO write.
- Sits beside the ALU in E. Operands come from the forwarded E-stage rs/rt values.

---
 rtl/div_ctrl.sv | 91 +++++++++
 tb/tb_div_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: iterative restoring DIV/DIVU sequencer for the E stage, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |a| < |b|.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div_running,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;
    stateType state;
    logic [CW-1:0] counter;
    logic [WIDTH-1:0] magA, magB, dvd, dvs, rem, remNext, qNext;
    logic [WIDTH:0] trial;
    logic signQ, signR, noBorrow, launch, earlyOut;
    always_comb begin
        magA = (signed_div && a[WIDTH-1]) ? -a : a;
        magB = (signed_div && b[WIDTH-1]) ? -b : b;
        launch = start && !annul;
        trial = {rem, dvd[WIDTH-1]};
        noBorrow = trial >= {1'b0, dvs};
        remNext = WIDTH'(noBorrow ? trial - {1'b0, dvs} : trial);
        qNext = {dvd[WIDTH-2:0], noBorrow};
`ifdef DIV_EARLY_OUT_EN
        earlyOut = (magA < magB) && (b != '0);
`else
        earlyOut = 1'b0;
`endif
    end
    // Held low during reset so a level start cannot request a stall.
    assign div_running = rst && ((state == IDLE && launch) || state == BUSY);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            counter <= '0;
            result_valid <= 1'b0;
            quotient <= '0;
            remainder <= '0;
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            signQ <= 1'b0;
            signR <= 1'b0;
        end else begin
            case (state)
                IDLE: if (launch) begin
                    signQ <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                    signR <= signed_div & a[WIDTH-1];
                    dvd <= magA;
                    dvs <= magB;
                    rem <= '0;
                    counter <= '0;
                    if (b == '0 || earlyOut) begin
                        quotient <= (b == '0) ? '1 : '0;
                        remainder <= a;
                        result_valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: if (annul) begin
                    state <= IDLE;
                end else begin
                    dvd <= qNext;
                    rem <= remNext;
                    counter <= counter + 1'b1;
                    if (counter == CW'(WIDTH - 1)) begin
                        quotient <= signQ ? -qNext : qNext;
                        remainder <= signR ? -remNext : remNext;
                        result_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl latency, signed/unsigned results, annul and reset.
module tb_div_ctrl;
    logic clk, rst, start, signedDiv, annul;
    logic [31:0] a, b, quotient, remainder;
    logic divRunning, resultValid;
    int vectors = 0;
    int miscompares = 0;

    div_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signedDiv), .annul(annul),
        .a(a), .b(b), .div_running(divRunning), .result_valid(resultValid),
        .quotient(quotient), .remainder(remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in the start cycle; runs until result_valid and checks latency and stall length.
    task automatic runTo(input string tag, input int expCyc, input logic [31:0] expQ, input logic [31:0] expR);
        int c = 0;
        int run = 0;
        while (!resultValid && c < 200) begin
            run += int'(divRunning);
            tick();
            c++;
        end
        chk({tag, "_cycles"}, c, expCyc);
        chk({tag, "_stall"}, run, expCyc);
        chk({tag, "_valid"}, resultValid, 1);
        chk({tag, "_runDone"}, divRunning, 0);
        chk({tag, "_q"}, quotient, expQ);
        chk({tag, "_r"}, remainder, expR);
    endtask

    task automatic after(input string tag, input logic [31:0] expQ, input logic [31:0] expR);
        start = 0;
        tick();
        chk({tag, "_pulse"}, resultValid, 0);
        chk({tag, "_holdQ"}, quotient, expQ);
        chk({tag, "_holdR"}, remainder, expR);
    endtask

    task automatic launch(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y);
        start = 1;
        signedDiv = s;
        a = x;
        b = y;
        #1;
        chk({tag, "_run0"}, divRunning, 1);
    endtask

    initial begin
        int rvSeen;
        rst = 1; start = 0; signedDiv = 0; annul = 0; a = 0; b = 0;
        #3 rst = 0;
        tick();
        tick();
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_valid", resultValid, 0);
        chk("rst_run", divRunning, 0);
        rst = 1;
        tick();

        launch("divu", 0, 100, 7);
        runTo("divu", 33, 14, 2);
        after("divu", 14, 2);

        launch("divNeg", 1, 32'hFFFF_FFF9, 2);
        runTo("divNeg", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        after("divNeg", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

        launch("divNegB", 1, 7, 32'hFFFF_FFFE);
        runTo("divNegB", 33, 32'hFFFF_FFFD, 1);
        after("divNegB", 32'hFFFF_FFFD, 1);

        launch("div0", 0, 32'h1234_5678, 0);
        runTo("div0", 1, 32'hFFFF_FFFF, 32'h1234_5678);
        after("div0", 32'hFFFF_FFFF, 32'h1234_5678);

        launch("ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF);
        runTo("ovf", 33, 32'h8000_0000, 0);
        after("ovf", 32'h8000_0000, 0);

        launch("annul", 0, 50, 5);
        for (int i = 0; i < 10; i++) tick();
        chk("annul_busy", divRunning, 1);
        annul = 1;
        tick();
        chk("annul_idle", divRunning, 0);
        chk("annul_valid", resultValid, 0);
        chk("annul_holdQ", quotient, 32'h8000_0000);
        start = 0;
        annul = 0;
        tick();
        launch("restart", 0, 50, 5);
        tick();
        a = 999;
        b = 1;
        runTo("restart", 32, 10, 0);
        after("restart", 10, 0);

        launch("b2b", 0, 9, 2);
        runTo("b2bFirst", 33, 4, 1);
        a = 20;
        b = 3;
        tick();
        chk("b2b_gap_valid", resultValid, 0);
        chk("b2b_gap_run", divRunning, 1);
        runTo("b2bSecond", 33, 6, 2);
        after("b2b", 6, 2);

        launch("rstMid", 0, 100, 7);
        for (int i = 0; i < 5; i++) tick();
        chk("rstMid_busy", divRunning, 1);
        rst = 0;
        #1;
        chk("rstMid_q", quotient, 0);
        chk("rstMid_r", remainder, 0);
        chk("rstMid_run", divRunning, 0);
        chk("rstMid_valid", resultValid, 0);
        tick();
        rst = 1;
        start = 0;
        rvSeen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            rvSeen += int'(resultValid);
        end
        chk("rstMid_noResult", rvSeen, 0);

`ifdef DIV_EARLY_OUT_EN
        launch("early", 0, 3, 10);
        runTo("early", 1, 0, 3);
`else
        launch("early", 0, 3, 10);
        runTo("early", 33, 0, 3);
`endif
        after("early", 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
